// File: rtl/pwm_key_multi.sv
// Multi-channel key-controlled PWM: per-channel up/down keys step a pending duty,
// which is copied into the active duty at each period boundary of a shared counter.
module pwm_key_multi #(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 4,
    parameter int PERIOD    = 10,
    parameter int STEP      = 2,
    parameter int INIT_DUTY = 0,
    parameter int WRAP      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        key_up,
    input  logic [N_CH-1:0]        key_dn,
    output logic [N_CH-1:0]        pwm_out,
    output logic [N_CH*CNT_W-1:0]  duty,
    output logic                   period_start
);

    localparam logic [CNT_W:0]   PERIOD_X = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_DUTY);

    logic [N_CH-1:0]  upMeta_q, upSync_q, upPrev_q;
    logic [N_CH-1:0]  dnMeta_q, dnSync_q, dnPrev_q;
    logic [N_CH-1:0]  upEvent, dnEvent;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cntLast;
    logic             periodStart_q;

    // Two-flop synchronisers followed by a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upMeta_q <= '0;
            upSync_q <= '0;
            upPrev_q <= '0;
            dnMeta_q <= '0;
            dnSync_q <= '0;
            dnPrev_q <= '0;
        end else begin
            upMeta_q <= key_up;
            upSync_q <= upMeta_q;
            upPrev_q <= upSync_q;
            dnMeta_q <= key_dn;
            dnSync_q <= dnMeta_q;
            dnPrev_q <= dnSync_q;
        end
    end

    assign upEvent = upSync_q & ~upPrev_q;
    assign dnEvent = dnSync_q & ~dnPrev_q;

    assign cntLast = (cnt_q == LAST_C);
    assign cnt_d   = cntLast ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            periodStart_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            periodStart_q <= (cnt_q == '0);
        end
    end

    assign period_start = periodStart_q;

    for (genvar i = 0; i < N_CH; i++) begin : gCh
        logic [CNT_W-1:0] pending_q, pending_d;
        logic [CNT_W-1:0] active_q, active_d;
        logic [CNT_W:0]   sumX, diffX;
        logic             pwm_q, pwm_d;

        // One extra bit exposes overflow past PERIOD and underflow below zero.
        assign sumX  = {1'b0, pending_q} + STEP_X;
        assign diffX = {1'b0, pending_q} - STEP_X;

        always_comb begin
            pending_d = pending_q;
            if (upEvent[i] && !dnEvent[i]) begin
                if (sumX > PERIOD_X) begin
                    pending_d = (WRAP != 0) ? '0 : PERIOD_C;
                end else begin
                    pending_d = sumX[CNT_W-1:0];
                end
            end else if (dnEvent[i] && !upEvent[i]) begin
                if (diffX[CNT_W]) begin
                    pending_d = (WRAP != 0) ? PERIOD_C : '0;
                end else begin
                    pending_d = diffX[CNT_W-1:0];
                end
            end
            active_d = cntLast ? pending_d : active_q;
            pwm_d    = (cnt_q < active_q);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending_q <= INIT_C;
                active_q  <= INIT_C;
                pwm_q     <= 1'b0;
            end else begin
                pending_q <= pending_d;
                active_q  <= active_d;
                pwm_q     <= pwm_d;
            end
        end

        assign pwm_out[i]                = pwm_q;
        assign duty[i*CNT_W +: CNT_W]    = active_q;
    end

endmodule

// File: tb/tb_pwm_key_multi.sv
// Directed self-checking bench for pwm_key_multi: a saturating instance and a
// wrapping instance share clock and reset.
module tb_pwm_key_multi;

    logic       clk;
    logic       rst_n;
    logic [1:0] keyUp, keyDn, keyUpW, keyDnW;
    logic [1:0] pwmOut, pwmOutW;
    logic [7:0] duty, dutyW;
    logic       periodStart, periodStartW;

    int testsRun = 0;
    int failCount = 0;

    pwm_key_multi #(.N_CH(2), .CNT_W(4), .PERIOD(10), .STEP(2), .INIT_DUTY(0), .WRAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .key_up(keyUp), .key_dn(keyDn),
        .pwm_out(pwmOut), .duty(duty), .period_start(periodStart)
    );

    pwm_key_multi #(.N_CH(2), .CNT_W(4), .PERIOD(10), .STEP(2), .INIT_DUTY(0), .WRAP(1)) dutW (
        .clk(clk), .rst_n(rst_n), .key_up(keyUpW), .key_dn(keyDnW),
        .pwm_out(pwmOutW), .duty(dutyW), .period_start(periodStartW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at the falling edge where the counter holds the target value.
    task automatic syncToCnt(input int target);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 25 && !found; n++) begin
            @(negedge clk);
            if (periodStart === 1'b1) found = 1'b1;
        end
        testsRun++;
        if (!found) begin
            failCount++;
            $display("[TB] FAIL sync_period_start: saw no pulse in 25 cycles, need a pulse");
        end
        repeat ((target + 9) % 10) @(negedge clk);
    endtask

    task automatic pressKey(input int which, input int ch, input int hold);
        case (which)
            0: keyUp[ch] = 1'b1;
            1: keyDn[ch] = 1'b1;
            2: keyUpW[ch] = 1'b1;
            default: keyDnW[ch] = 1'b1;
        endcase
        repeat (hold) @(negedge clk);
        case (which)
            0: keyUp[ch] = 1'b0;
            1: keyDn[ch] = 1'b0;
            2: keyUpW[ch] = 1'b0;
            default: keyDnW[ch] = 1'b0;
        endcase
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        keyUp = '0; keyDn = '0; keyUpW = '0; keyDnW = '0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (pwmOut !== 2'b00 || duty !== 8'h00 || periodStart !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: pwm=%b duty=%h ps=%b, need 00 00 0", pwmOut, duty, periodStart);
        end
        testsRun++;
        if (pwmOutW !== 2'b00 || dutyW !== 8'h00 || periodStartW !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs_wrap: pwm=%b duty=%h ps=%b, need 00 00 0", pwmOutW, dutyW, periodStartW);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            testsRun++;
            if (periodStart !== (k % 10 == 1)) begin
                failCount++;
                $display("[TB] FAIL reset_period_start k=%0d: got %b, need %b", k, periodStart, (k % 10 == 1));
            end
        end
        testsRun++;
        if (pwmOut !== 2'b00 || duty !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_idle: pwm=%b duty=%h, need 00 00", pwmOut, duty);
        end
    endtask

    task automatic test_single_step;
        syncToCnt(1);
        keyUp[0] = 1'b1;
        repeat (5) @(negedge clk);
        keyUp[0] = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (duty[3:0] !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL step_before_boundary: duty0=%0d, need 0", duty[3:0]);
        end
        @(negedge clk);
        testsRun++;
        if (duty[3:0] !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL step_after_boundary: duty0=%0d, need 2", duty[3:0]);
        end
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            testsRun++;
            if (pwmOut !== {1'b0, (j <= 2)}) begin
                failCount++;
                $display("[TB] FAIL step_pwm j=%0d: pwm=%b, need %b", j, pwmOut, {1'b0, (j <= 2)});
            end
        end
        testsRun++;
        if (duty[7:4] !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL step_ch1_idle: duty1=%0d, need 0", duty[7:4]);
        end
    endtask

    task automatic test_saturate;
        for (int p = 0; p < 6; p++) pressKey(0, 1, 2);
        repeat (3) @(negedge clk);
        syncToCnt(1);
        testsRun++;
        if (duty[7:4] !== 4'd10) begin
            failCount++;
            $display("[TB] FAIL sat_high_duty: duty1=%0d, need 10", duty[7:4]);
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            testsRun++;
            if (pwmOut[1] !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL sat_high_pwm j=%0d: pwm1=%b, need 1", j, pwmOut[1]);
            end
        end
        for (int p = 0; p < 6; p++) pressKey(1, 1, 2);
        repeat (3) @(negedge clk);
        syncToCnt(1);
        testsRun++;
        if (duty[7:4] !== 4'd0 || duty[3:0] !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL sat_low_duty: duty1=%0d duty0=%0d, need 0 and 2", duty[7:4], duty[3:0]);
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            testsRun++;
            if (pwmOut[1] !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL sat_low_pwm j=%0d: pwm1=%b, need 0", j, pwmOut[1]);
            end
        end
    endtask

    task automatic test_wrap;
        for (int p = 0; p < 5; p++) pressKey(2, 0, 2);
        repeat (3) @(negedge clk);
        syncToCnt(1);
        testsRun++;
        if (dutyW[3:0] !== 4'd10) begin
            failCount++;
            $display("[TB] FAIL wrap_fill: duty0=%0d, need 10", dutyW[3:0]);
        end
        pressKey(2, 0, 2);
        repeat (3) @(negedge clk);
        syncToCnt(1);
        testsRun++;
        if (dutyW[3:0] !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL wrap_up: duty0=%0d, need 0", dutyW[3:0]);
        end
        pressKey(3, 0, 2);
        repeat (3) @(negedge clk);
        syncToCnt(1);
        testsRun++;
        if (dutyW[3:0] !== 4'd10) begin
            failCount++;
            $display("[TB] FAIL wrap_dn: duty0=%0d, need 10", dutyW[3:0]);
        end
    endtask

    task automatic test_key_corners;
        keyUp[0] = 1'b1;
        keyDn[0] = 1'b1;
        repeat (3) @(negedge clk);
        keyUp[0] = 1'b0;
        keyDn[0] = 1'b0;
        repeat (3) @(negedge clk);
        syncToCnt(1);
        testsRun++;
        if (duty[3:0] !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL both_keys: duty0=%0d, need 2", duty[3:0]);
        end
        keyUp[0] = 1'b1;
        repeat (30) @(negedge clk);
        keyUp[0] = 1'b0;
        repeat (3) @(negedge clk);
        syncToCnt(1);
        testsRun++;
        if (duty[3:0] !== 4'd4) begin
            failCount++;
            $display("[TB] FAIL held_key: duty0=%0d, need 4", duty[3:0]);
        end
        syncToCnt(7);
        keyUp[0] = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (duty[3:0] !== 4'd4) begin
            failCount++;
            $display("[TB] FAIL boundary_event_pre: duty0=%0d, need 4", duty[3:0]);
        end
        @(negedge clk);
        testsRun++;
        if (duty[3:0] !== 4'd6) begin
            failCount++;
            $display("[TB] FAIL boundary_event_load: duty0=%0d, need 6", duty[3:0]);
        end
        keyUp[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        syncToCnt(4);
        testsRun++;
        if (pwmOut !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL pre_reset_pwm: pwm=%b, need 01", pwmOut);
        end
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if (pwmOut !== 2'b00 || duty !== 8'h00 || periodStart !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset: pwm=%b duty=%h ps=%b, need 00 00 0", pwmOut, duty, periodStart);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            testsRun++;
            if (pwmOut !== 2'b00 || duty !== 8'h00 || periodStart !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL reset_hold j=%0d: pwm=%b duty=%h ps=%b", j, pwmOut, duty, periodStart);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            testsRun++;
            if (periodStart !== (k == 1 || k == 11)) begin
                failCount++;
                $display("[TB] FAIL release_period_start k=%0d: got %b, need %b", k, periodStart, (k == 1 || k == 11));
            end
        end
        testsRun++;
        if (duty !== 8'h00 || pwmOut !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL release_duty: duty=%h pwm=%b, need 00 00", duty, pwmOut);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_saturate();
        test_wrap();
        test_key_corners();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
